rs_issue_arbiter: RTL and testbench
===================================

Name: rs_issue_arbiter

Overview:
- Issue arbiter between the ALU and LS reservation stations.
- Replaces the ad-hoc ALU stall logic in the RS wrapper. Decides each cycle which RS may issue, so at most one FU starts per cycle.
- Tracks LS occupancy (multi-cycle memory op) with a small FSM.
- Prevents ALU starvation with a saturating counter and blocks issue for a fixed window after a branch mispredict.

Parameters:
- STARVE_LIMIT, 3, consecutive ALU losses after which the ALU wins the next conflict (legal range 1..15).
- STARVE_W, 4, width of the starvation counter; must hold STARVE_LIMIT.
- FLUSH_CYCLES, 2, cycles of issue blocking after the mispredict cycle (legal range 1..15).

Ports:
- in_clk  input  1  clock, all state on posedge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_alu_has_ready  input  1  ALU RS holds at least one ready entry.
- in_ls_has_ready  input  1  LS RS holds at least one ready entry.
- in_fu_alu_ready  input  1  ALU FU can accept an op this cycle.
- in_ls_done  input  1  LS FU completes its current op (1-cycle pulse).
- in_rob_is_mispred  input  1  ROB mispredict flush (1-cycle pulse).
- out_alu_start  output  1  registered issue pulse to the ALU RS/FU.
- out_ls_start  output  1  registered issue pulse to the LS RS/FU.
- out_alu_stall  output  1  registered; ALU was eligible but lost arbitration.
- out_ls_busy  output  1  LS FSM is not in LS_IDLE.
- out_ls_discard  output  1  combinational; in_ls_done belongs to a flushed op and must not write back.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all outputs 0;
  - LS FSM in LS_IDLE;
  - starvation counter 0;
  - flush counter 0.
- Flush block: flush_blk = in_rob_is_mispred | (flush_cnt != 0).
- Eligibility, evaluated in cycle t:
  - alu_elig = in_alu_has_ready & in_fu_alu_ready & ~flush_blk;
  - ls_elig = in_ls_has_ready & (state == LS_IDLE) & ~flush_blk.
- Arbitration:
  - only alu_elig: grant ALU;
  - only ls_elig: grant LS;
  - both: grant ALU if starve_cnt == STARVE_LIMIT, else grant LS;
  - at most one grant per cycle.
- Latency: a grant decided in cycle t appears on out_*_start in cycle t+1 for exactly one cycle.
- out_alu_stall(t+1) = alu_elig(t) & ~alu_grant(t).
- Starvation counter:
  - cleared on ALU grant;
  - incremented on alu_elig & ~alu_grant, saturating at STARVE_LIMIT;
  - held otherwise.
- LS FSM states: LS_IDLE, LS_BUSY, LS_DRAIN.
  - LS_IDLE -> LS_BUSY on LS grant (same edge that raises out_ls_start).
  - LS_BUSY -> LS_IDLE on in_ls_done.
  - LS_BUSY -> LS_DRAIN on in_rob_is_mispred without in_ls_done.
  - LS_BUSY with in_ls_done and in_rob_is_mispred together -> LS_IDLE; that completion is kept (not discarded).
  - LS_DRAIN -> LS_IDLE on in_ls_done.
  - LS_DRAIN also returns to LS_IDLE on in_ls_done when a new mispredict arrives in the same cycle.
  - in_ls_done in LS_IDLE is ignored; no state change.
- out_ls_discard = (state == LS_DRAIN) & in_ls_done.
- Flush counter:
  - loaded with FLUSH_CYCLES on in_rob_is_mispred, including a reload while already counting;
  - otherwise decrements to 0.
  - Result: a mispredict in cycle t blocks grants decided in t..t+FLUSH_CYCLES, so starts are 0 in t+1..t+FLUSH_CYCLES+1.
- A grant decided in the mispredict cycle is suppressed. A start already on the outputs in the mispredict cycle is not retracted; the RS owns squashing it.
- Starvation counter is not cleared by mispredict.

Optional Feature:
- Macro: RS_ARB_PERF_CNT_EN.
- When defined, adds output out_conflict_cnt (32 bits):
  - counts cycles with alu_elig & ls_elig;
  - wraps at 2^32;
  - reset to 0;
  - unaffected by mispredict.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-op: LS_BUSY, assert in_rst between edges -> out_ls_busy=0 and starts=0 immediately, before the next edge; after release, in_ls_has_ready=1 -> out_ls_start=1 one cycle later.
- Solo issue: in_alu_has_ready=1, in_fu_alu_ready=1, LS idle with no request -> out_alu_start=1 every cycle from cycle 2; out_alu_stall=0.
- Conflict plus starvation, STARVE_LIMIT=3, both requesting every cycle, in_ls_done pulsed the cycle after each LS start:
  - LS wins conflicts 1-3 and out_alu_stall=1 on each;
  - ALU wins conflict 4;
  - counter returns to 0 and LS wins conflict 5.
- LS busy: LS granted, in_ls_done held 0 for 5 cycles -> out_ls_start=0 and out_ls_busy=1 throughout; ALU keeps issuing; in_ls_done=1 -> LS may issue again next cycle.
- Mispredict drain, FLUSH_CYCLES=2, LS_BUSY:
  - mispredict at cycle 10 -> starts=0 in cycles 11-13, issue resumes at cycle 14;
  - in_ls_done at cycle 12 -> out_ls_discard=1 in cycle 12 only; state returns to LS_IDLE.
- Perf counter: with RS_ARB_PERF_CNT_EN defined, 7 conflict cycles -> out_conflict_cnt=7; compile without the macro -> port absent, other outputs unchanged.

Source files
------------

// File: rtl/rs_issue_arbiter_if.sv
// rs_issue_arbiter_if: request/issue bundle between the RS wrapper and the issue arbiter.
interface rs_issue_arbiter_if;
    logic in_alu_has_ready;
    logic in_ls_has_ready;
    logic in_fu_alu_ready;
    logic in_ls_done;
    logic in_rob_is_mispred;
    logic out_alu_start;
    logic out_ls_start;
    logic out_alu_stall;
    logic out_ls_busy;
    logic out_ls_discard;
    modport master (
        output in_alu_has_ready, in_ls_has_ready, in_fu_alu_ready, in_ls_done, in_rob_is_mispred,
        input  out_alu_start, out_ls_start, out_alu_stall, out_ls_busy, out_ls_discard
    );
    modport slave (
        input  in_alu_has_ready, in_ls_has_ready, in_fu_alu_ready, in_ls_done, in_rob_is_mispred,
        output out_alu_start, out_ls_start, out_alu_stall, out_ls_busy, out_ls_discard
    );
endinterface

// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter: one-issue-per-cycle arbiter between ALU and LS RS, with LS occupancy FSM,
// ALU anti-starvation and post-mispredict issue blocking. RS_ARB_PERF_CNT_EN adds a conflict counter.
module rs_issue_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int STARVE_W     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               in_clk,
    input  logic               in_rst,
`ifdef RS_ARB_PERF_CNT_EN
    output logic [31:0]        out_conflict_cnt,
`endif
    rs_issue_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {LS_IDLE, LS_BUSY, LS_DRAIN} ls_state_t;
    ls_state_t state, state_nxt;
    logic [STARVE_W-1:0] starve_cnt, starve_nxt;
    logic [3:0] flush_cnt, flush_nxt;
    logic flush_blk, alu_elig, ls_elig, starved, alu_grant, ls_grant;
    always_comb begin
        flush_blk  = bus.in_rob_is_mispred | (flush_cnt != 4'd0);
        alu_elig   = bus.in_alu_has_ready & bus.in_fu_alu_ready & ~flush_blk;
        ls_elig    = bus.in_ls_has_ready & (state == LS_IDLE) & ~flush_blk;
        starved    = starve_cnt == STARVE_W'(STARVE_LIMIT);
        alu_grant  = alu_elig & (~ls_elig | starved);
        ls_grant   = ls_elig & ~alu_grant;
        starve_nxt = alu_grant ? '0 : (alu_elig & ~starved) ? starve_cnt + STARVE_W'(1) : starve_cnt;
        flush_nxt  = bus.in_rob_is_mispred ? 4'(FLUSH_CYCLES) : (flush_cnt != 4'd0) ? flush_cnt - 4'd1 : flush_cnt;
        // A completion that coincides with the mispredict still belongs to a live op
        state_nxt  = (state == LS_IDLE) ? (ls_grant ? LS_BUSY : LS_IDLE) :
                     bus.in_ls_done ? LS_IDLE :
                     (state == LS_BUSY && bus.in_rob_is_mispred) ? LS_DRAIN : state;
    end
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state             <= LS_IDLE;
            starve_cnt        <= '0;
            flush_cnt         <= 4'd0;
            bus.out_alu_start <= 1'b0;
            bus.out_ls_start  <= 1'b0;
            bus.out_alu_stall <= 1'b0;
        end else begin
            state             <= state_nxt;
            starve_cnt        <= starve_nxt;
            flush_cnt         <= flush_nxt;
            bus.out_alu_start <= alu_grant;
            bus.out_ls_start  <= ls_grant;
            bus.out_alu_stall <= alu_elig & ~alu_grant;
        end
    end
    assign bus.out_ls_busy    = state != LS_IDLE;
    assign bus.out_ls_discard = (state == LS_DRAIN) & bus.in_ls_done;
`ifdef RS_ARB_PERF_CNT_EN
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) out_conflict_cnt <= 32'd0;
        else if (alu_elig & ls_elig) out_conflict_cnt <= out_conflict_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_rs_issue_arbiter.sv
// tb_rs_issue_arbiter: directed scenario bench for rs_issue_arbiter (default STARVE_LIMIT=3, FLUSH_CYCLES=2).
module tb_rs_issue_arbiter;
    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    int tests = 0;
    int fails = 0;
    rs_issue_arbiter_if bus();
`ifdef RS_ARB_PERF_CNT_EN
    logic [31:0] out_conflict_cnt;
    rs_issue_arbiter dut (.in_clk(in_clk), .in_rst(in_rst), .out_conflict_cnt(out_conflict_cnt), .bus(bus));
`else
    rs_issue_arbiter dut (.in_clk(in_clk), .in_rst(in_rst), .bus(bus));
`endif
    always #5 in_clk = ~in_clk;

    task automatic set_idle;
        bus.in_alu_has_ready = 0; bus.in_ls_has_ready = 0; bus.in_fu_alu_ready = 0;
        bus.in_ls_done = 0; bus.in_rob_is_mispred = 0;
    endtask

    task automatic tick;
        @(posedge in_clk); #1;
    endtask

    task automatic reset_dut;
        set_idle(); in_rst = 1; tick(); in_rst = 0;
    endtask

    task automatic test_reset;
        set_idle(); in_rst = 1; tick();
        tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_alu_stall, bus.out_ls_busy, bus.out_ls_discard} !== 5'b0) begin fails++; $display("FAIL reset_state: got %b exp 00000", {bus.out_alu_start, bus.out_ls_start, bus.out_alu_stall, bus.out_ls_busy, bus.out_ls_discard}); end
        in_rst = 0; bus.in_ls_has_ready = 1; tick();
        tests++; if ({bus.out_ls_start, bus.out_ls_busy} !== 2'b11) begin fails++; $display("FAIL reset_ls_go: got %b exp 11", {bus.out_ls_start, bus.out_ls_busy}); end
        bus.in_ls_has_ready = 0; #2 in_rst = 1; #1;
        tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy} !== 3'b0) begin fails++; $display("FAIL reset_midop_async: got %b exp 000", {bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy}); end
        #1 in_rst = 0; bus.in_ls_has_ready = 1; tick();
        tests++; if (bus.out_ls_start !== 1'b1) begin fails++; $display("FAIL reset_release_ls: got %b exp 1", bus.out_ls_start); end
    endtask

    task automatic test_solo;
        reset_dut(); bus.in_alu_has_ready = 1; bus.in_fu_alu_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if ({bus.out_alu_start, bus.out_alu_stall, bus.out_ls_start} !== 3'b100) begin fails++; $display("FAIL solo_alu[%0d]: got %b exp 100", i, {bus.out_alu_start, bus.out_alu_stall, bus.out_ls_start}); end
        end
    endtask

    // Between conflicts the ALU is held not-ready so its loss streak is not reset by a solo win
    task automatic test_starvation;
        logic [2:0] exp;
        reset_dut();
        for (int k = 1; k <= 5; k++) begin
            set_idle(); bus.in_alu_has_ready = 1; bus.in_fu_alu_ready = 1; bus.in_ls_has_ready = 1;
            tick();
            exp = (k == 4) ? 3'b100 : 3'b011;
            tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_alu_stall} !== exp) begin fails++; $display("FAIL starve_conflict%0d: got %b exp %b", k, {bus.out_alu_start, bus.out_ls_start, bus.out_alu_stall}, exp); end
            set_idle(); bus.in_alu_has_ready = 1; bus.in_ls_done = 1;
            tick();
            tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy} !== 3'b000) begin fails++; $display("FAIL starve_gap%0d: got %b exp 000", k, {bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy}); end
        end
        set_idle();
    endtask

    task automatic test_ls_busy;
        reset_dut(); bus.in_alu_has_ready = 1; bus.in_fu_alu_ready = 1; bus.in_ls_has_ready = 1;
        tick();
        tests++; if ({bus.out_alu_start, bus.out_ls_start} !== 2'b01) begin fails++; $display("FAIL busy_first: got %b exp 01", {bus.out_alu_start, bus.out_ls_start}); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy} !== 3'b101) begin fails++; $display("FAIL busy_hold[%0d]: got %b exp 101", i, {bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy}); end
        end
        bus.in_ls_done = 1; tick(); bus.in_ls_done = 0;
        tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy} !== 3'b100) begin fails++; $display("FAIL busy_done: got %b exp 100", {bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy}); end
        tick();
        tests++; if (bus.out_ls_start !== 1'b1) begin fails++; $display("FAIL busy_reissue: got %b exp 1", bus.out_ls_start); end
        set_idle();
    endtask

    task automatic test_mispredict;
        reset_dut(); bus.in_ls_has_ready = 1; tick();
        bus.in_alu_has_ready = 1; bus.in_fu_alu_ready = 1; tick();
        tests++; if ({bus.out_alu_start, bus.out_ls_busy} !== 2'b11) begin fails++; $display("FAIL mp_pre: got %b exp 11", {bus.out_alu_start, bus.out_ls_busy}); end
        bus.in_rob_is_mispred = 1; tick(); bus.in_rob_is_mispred = 0;
        tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy, bus.out_ls_discard} !== 4'b0010) begin fails++; $display("FAIL mp_t1: got %b exp 0010", {bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy, bus.out_ls_discard}); end
        tick();
        tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_ls_discard} !== 3'b000) begin fails++; $display("FAIL mp_t2: got %b exp 000", {bus.out_alu_start, bus.out_ls_start, bus.out_ls_discard}); end
        bus.in_ls_done = 1; #1;
        tests++; if (bus.out_ls_discard !== 1'b1) begin fails++; $display("FAIL mp_discard: got %b exp 1", bus.out_ls_discard); end
        tick(); bus.in_ls_done = 0;
        tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy, bus.out_ls_discard} !== 4'b0000) begin fails++; $display("FAIL mp_t3: got %b exp 0000", {bus.out_alu_start, bus.out_ls_start, bus.out_ls_busy, bus.out_ls_discard}); end
        tick();
        tests++; if ({bus.out_alu_start, bus.out_ls_start, bus.out_alu_stall} !== 3'b011) begin fails++; $display("FAIL mp_resume: got %b exp 011", {bus.out_alu_start, bus.out_ls_start, bus.out_alu_stall}); end
        set_idle();
    endtask

    task automatic test_ls_edges;
        reset_dut(); bus.in_ls_has_ready = 1; tick();
        bus.in_ls_has_ready = 0; bus.in_rob_is_mispred = 1; bus.in_ls_done = 1; #1;
        tests++; if (bus.out_ls_discard !== 1'b0) begin fails++; $display("FAIL edge_keep_done: got %b exp 0", bus.out_ls_discard); end
        tick(); set_idle();
        tests++; if (bus.out_ls_busy !== 1'b0) begin fails++; $display("FAIL edge_busy_to_idle: got %b exp 0", bus.out_ls_busy); end
        bus.in_ls_has_ready = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (bus.out_ls_start !== 1'b0) begin fails++; $display("FAIL edge_flush_blk[%0d]: got %b exp 0", i, bus.out_ls_start); end
        end
        tick();
        tests++; if (bus.out_ls_start !== 1'b1) begin fails++; $display("FAIL edge_flush_end: got %b exp 1", bus.out_ls_start); end
        bus.in_ls_has_ready = 0; bus.in_rob_is_mispred = 1; tick();
        tests++; if (bus.out_ls_busy !== 1'b1) begin fails++; $display("FAIL edge_drain: got %b exp 1", bus.out_ls_busy); end
        bus.in_ls_done = 1; #1;
        tests++; if (bus.out_ls_discard !== 1'b1) begin fails++; $display("FAIL edge_drain_discard: got %b exp 1", bus.out_ls_discard); end
        tick(); set_idle();
        tests++; if (bus.out_ls_busy !== 1'b0) begin fails++; $display("FAIL edge_drain_idle: got %b exp 0", bus.out_ls_busy); end
        bus.in_ls_done = 1; tick(); set_idle();
        tests++; if (bus.out_ls_busy !== 1'b0) begin fails++; $display("FAIL edge_idle_done: got %b exp 0", bus.out_ls_busy); end
    endtask

    task automatic test_flush_reload;
        reset_dut(); bus.in_alu_has_ready = 1; bus.in_fu_alu_ready = 1; tick();
        tests++; if (bus.out_alu_start !== 1'b1) begin fails++; $display("FAIL reload_pre: got %b exp 1", bus.out_alu_start); end
        for (int i = 0; i < 6; i++) begin
            bus.in_rob_is_mispred = (i == 0 || i == 2);
            tick();
            tests++; if (bus.out_alu_start !== (i == 5)) begin fails++; $display("FAIL reload_t%0d: got %b exp %b", i, bus.out_alu_start, i == 5); end
        end
        set_idle();
    endtask

`ifdef RS_ARB_PERF_CNT_EN
    task automatic test_perf;
        reset_dut();
        for (int k = 0; k < 7; k++) begin
            set_idle(); bus.in_alu_has_ready = 1; bus.in_fu_alu_ready = 1; bus.in_ls_has_ready = 1; tick();
            set_idle(); bus.in_ls_done = 1; tick();
        end
        set_idle();
        tests++; if (out_conflict_cnt !== 32'd7) begin fails++; $display("FAIL perf_cnt: got %0d exp 7", out_conflict_cnt); end
    endtask
`endif

    initial begin
        set_idle();
        test_reset();
        test_solo();
        test_starvation();
        test_ls_busy();
        test_mispredict();
        test_ls_edges();
        test_flush_reload();
`ifdef RS_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
